// File: rtl/decoder_3to8_buf.sv
// ---------------------------------------------------------------------------
// decoder_3to8_buf
//
// Purpose:
//   Decodes a 3-bit encoded index (e, v) into a one-hot 8-bit word and buffers
//   the decoded words in a 2-entry FIFO with valid/ready handshakes on both
//   sides. Decoding happens when a word is written, so the FIFO holds decoded
//   words. The block also counts accepted words, and separately counts
//   accepted words with v=0.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   e          in   [0:2]  encoded index, e[0] is MSB, n = 0..7
//   v          in   1      1: line n active; 0: no line active (d = 0)
//   in_valid   in   1      upstream word (e, v) present
//   in_ready   out  1      block can accept a word (level < 2)
//   d          out  [0:7]  head decoded word, d[0] is MSB; 0 when empty
//   out_valid  out  1      d holds a valid word (level > 0)
//   out_ready  in   1      downstream accepts d this cycle
//   level      out  [1:0]  buffer occupancy 0..2
//   count      out  [7:0]  accepted words since reset, modulo 256
//   zero_cnt   out  [7:0]  accepted words with v=0, modulo 256
// ---------------------------------------------------------------------------
module decoder_3to8_buf (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [0:2] e,
   input  logic       v,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [0:7] d,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [1:0] level,
   output logic [7:0] count,
   output logic [7:0] zero_cnt
);

   // One-hot decode. Bit idx of a [0:7] vector is counted from the MSB, so
   // n=0 lands on d[0] (the MSB). When vld=0 the index is never used, so an
   // unknown index cannot leak into the result.
   function automatic logic [0:7] f_decode(input logic [0:2] idx, input logic vld);
      logic [0:7] res;
      res = '0;
      if (vld) begin
         res[idx] = 1'b1;
      end
      return res;
   endfunction

   logic [0:7] r_mem [0:1];
   logic       r_wp;
   logic       r_rp;
   logic [1:0] r_level;
   logic [7:0] r_count;
   logic [7:0] r_zero_cnt;

   logic       w_in_ready;
   logic       w_out_valid;
   logic       w_wr;
   logic       w_rd;
   logic [0:7] w_dec;

   // Handshake flags depend only on registered occupancy, never on out_ready.
   assign w_in_ready  = (r_level < 2'd2);
   assign w_out_valid = (r_level != 2'd0);
   assign w_wr        = in_valid & w_in_ready;
   assign w_rd        = w_out_valid & out_ready;
   assign w_dec       = f_decode(e, v);

   // Control state: pointers, occupancy and counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp       <= 1'b0;
         r_rp       <= 1'b0;
         r_level    <= 2'd0;
         r_count    <= 8'd0;
         r_zero_cnt <= 8'd0;
      end else begin
         if (w_wr) begin
            r_wp    <= ~r_wp;
            r_count <= r_count + 8'd1;
            if (!v) begin
               r_zero_cnt <= r_zero_cnt + 8'd1;
            end
         end
         if (w_rd) begin
            r_rp <= ~r_rp;
         end
         case ({w_wr, w_rd})
            2'b10:   r_level <= r_level + 2'd1;
            2'b01:   r_level <= r_level - 2'd1;
            default: r_level <= r_level;
         endcase
      end
   end

   // Storage holds data only; its contents are meaningless while level
   // says the slot is empty, so it carries no reset.
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wp] <= w_dec;
      end
   end

   // Empty buffer presents zero, so the async reset clears d immediately.
   assign d         = w_out_valid ? r_mem[r_rp] : 8'h00;
   assign in_ready  = w_in_ready;
   assign out_valid = w_out_valid;
   assign level     = r_level;
   assign count     = r_count;
   assign zero_cnt  = r_zero_cnt;

endmodule

// File: tb/tb_decoder_3to8_buf.sv
module tb_decoder_3to8_buf;

   logic       clk;
   logic       rst_n;
   logic [0:2] e;
   logic       v;
   logic       in_valid;
   logic       in_ready;
   logic [0:7] d;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] level;
   logic [7:0] count;
   logic [7:0] zero_cnt;

   int n_checks;
   int n_errors;

   decoder_3to8_buf dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .e         (e),
      .v         (v),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .d         (d),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .level     (level),
      .count     (count),
      .zero_cnt  (zero_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset pulse placed between edges.
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n     = 1'b0;
      e         = 3'd0;
      v         = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_d", 32'(d), 32'h00);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_zero_cnt", 32'(zero_cnt), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      step();
      rst_n = 1'b1;

      // Sweep n=0..7 back-to-back with out_ready=1.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      v         = 1'b1;
      for (int n = 0; n < 8; n++) begin
         e = 3'(n);
         step();
         chk($sformatf("sweep_d_%0d", n), 32'(d), 32'(8'h80 >> n));
         chk($sformatf("sweep_lvl_%0d", n), 32'(level), 32'd1);
      end
      in_valid = 1'b0;
      step();
      chk("sweep_count", 32'(count), 32'd8);
      chk("sweep_drain_ov", 32'(out_valid), 32'd0);
      chk("sweep_drain_d", 32'(d), 32'h00);

      // v=0 with e=101, then v=0 with unknown e.
      do_reset();
      step();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      v         = 1'b0;
      e         = 3'b101;
      step();
      chk("v0_d", 32'(d), 32'h00);
      chk("v0_out_valid", 32'(out_valid), 32'd1);
      chk("v0_zero_cnt", 32'(zero_cnt), 32'd1);
      chk("v0_count", 32'(count), 32'd1);
      e         = 3'bxxx;
      out_ready = 1'b1;
      step();
      chk("v0x_d", 32'(d), 32'h00);
      chk("v0x_zero_cnt", 32'(zero_cnt), 32'd2);
      in_valid = 1'b0;
      step();
      chk("v0x_drain", 32'(level), 32'd0);

      // Backpressure: n=2,5,6 with out_ready=0.
      do_reset();
      step();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      v         = 1'b1;
      e         = 3'd2;
      step();
      chk("bp_d_first", 32'(d), 32'h20);
      e = 3'd5;
      step();
      chk("bp_level2", 32'(level), 32'd2);
      chk("bp_in_ready0", 32'(in_ready), 32'd0);
      e = 3'd6;
      step();
      chk("bp_held_count", 32'(count), 32'd2);
      chk("bp_held_d", 32'(d), 32'h20);
      // Full with read+write request: only the read happens.
      out_ready = 1'b1;
      step();
      chk("full_rw_level", 32'(level), 32'd1);
      chk("full_rw_d", 32'(d), 32'h04);
      chk("full_rw_count", 32'(count), 32'd2);
      step();
      chk("bp_d_third", 32'(d), 32'h02);
      chk("bp_count3", 32'(count), 32'd3);
      in_valid = 1'b0;
      step();
      chk("bp_drain_level", 32'(level), 32'd0);

      // Counter wrap after 256 transfers.
      do_reset();
      step();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      v         = 1'b1;
      for (int i = 0; i < 256; i++) begin
         e = 3'(i % 8);
         step();
      end
      chk("wrap_count", 32'(count), 32'd0);
      chk("wrap_zero_cnt", 32'(zero_cnt), 32'd0);
      e = 3'd3;
      step();
      chk("wrap_count_257", 32'(count), 32'd1);
      chk("wrap_d_257", 32'(d), 32'h10);
      in_valid = 1'b0;
      step();

      // Mid-stream asynchronous reset with a full buffer.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      e         = 3'd1;
      step();
      e = 3'd7;
      step();
      chk("mid_level2", 32'(level), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ov", 32'(out_valid), 32'd0);
      chk("mid_rst_d", 32'(d), 32'h00);
      chk("mid_rst_level", 32'(level), 32'd0);
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      step();
      chk("mid_rst_no_xfer", 32'(count), 32'd0);
      #2;
      rst_n = 1'b1;
      e     = 3'd4;
      step();
      chk("post_rst_d", 32'(d), 32'h08);
      chk("post_rst_count", 32'(count), 32'd1);
      in_valid = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
